// File: rtl/wic_int_arb.sv
// WIC pending-vector arbiter: selects one enabled pending interrupt, presents it with valid/ack, and issues a one-hot clear.
// Define WIC_ARB_RR_EN for round-robin arbitration; the default build uses fixed lowest-index priority.
module wic_int_arb #(
   parameter int unsigned NUM_INT  = 32,
   parameter int unsigned WAIT_CYC = 4
) (
   input  logic               wic_clk,
   input  logic               pad_cpu_rst,
   input  logic [NUM_INT-1:0] int_pending,
   input  logic [NUM_INT-1:0] ctl_xx_awake_enable,
   input  logic               cpu_arb_int_ack,
   output logic               arb_int_vld,
   output logic [4:0]         arb_int_id,
   output logic               vec_int,
   output logic [4:0]         int_ack_vec,
   output logic [NUM_INT-1:0] pending_clr
);

   typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_CLR, ST_WAIT} state_t;

   state_t                state;
   logic   [4:0]          id_q;
   logic   [3:0]          cnt;
   logic   [NUM_INT-1:0]  masked;
   logic   [4:0]          winner;

   // Last write wins, so scanning from the top leaves the lowest set index.
   function automatic logic [4:0] lowest(input logic [NUM_INT-1:0] v);
      logic [4:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < NUM_INT; i++) begin
         if (v[NUM_INT-1-i]) idx = 5'(NUM_INT-1-i);
      end
      return idx;
   endfunction

`ifdef WIC_ARB_RR_EN
   logic [4:0]         ptr;
   logic [NUM_INT-1:0] rot;

   // Rotate so the pointer position becomes bit 0, then undo the offset.
   always_comb begin
      masked = int_pending & ctl_xx_awake_enable;
      rot    = (masked >> ptr) | (masked << (6'd32 - {1'b0, ptr}));
      winner = lowest(rot) + ptr;
   end
`else
   always_comb begin
      masked = int_pending & ctl_xx_awake_enable;
      winner = lowest(masked);
   end
`endif

   always_ff @(posedge wic_clk) begin
      if (pad_cpu_rst) begin
         state       <= ST_IDLE;
         id_q        <= '0;
         cnt         <= '0;
         arb_int_vld <= 1'b0;
         arb_int_id  <= '0;
         vec_int     <= 1'b0;
         int_ack_vec <= '0;
         pending_clr <= '0;
`ifdef WIC_ARB_RR_EN
         ptr         <= '0;
`endif
      end else begin
         vec_int     <= 1'b0;
         int_ack_vec <= '0;
         pending_clr <= '0;
         case (state)
            ST_IDLE: begin
               if (|masked) begin
                  id_q        <= winner;
                  arb_int_id  <= winner;
                  arb_int_vld <= 1'b1;
                  state       <= ST_REQ;
               end
            end
            ST_REQ: begin
               // Ack takes precedence over a simultaneous pending drop.
               if (cpu_arb_int_ack) begin
                  arb_int_vld <= 1'b0;
                  vec_int     <= 1'b1;
                  int_ack_vec <= id_q;
                  pending_clr <= NUM_INT'(1) << id_q;
                  state       <= ST_CLR;
               end else if (!int_pending[id_q]) begin
                  arb_int_vld <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            ST_CLR: begin
               cnt   <= '0;
               state <= ST_WAIT;
`ifdef WIC_ARB_RR_EN
               ptr   <= id_q + 5'd1;
`endif
            end
            ST_WAIT: begin
               if (!int_pending[id_q] || cnt == 4'(WAIT_CYC - 1)) begin
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + 4'd1;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wic_int_arb.sv
// Self-checking bench for wic_int_arb: directed plan steps plus random transactions against a transaction-level model.
module tb_wic_int_arb;
   localparam int unsigned WC = 4;

   logic        clk;
   logic        rst;
   logic [31:0] pend;
   logic [31:0] msk;
   logic        ack;
   logic        vld;
   logic [4:0]  id;
   logic        vec;
   logic [4:0]  ack_vec;
   logic [31:0] clr;

   int          total = 0;
   int          bad   = 0;
   int unsigned ptr_m = 0;
   bit          rr_en;

   wic_int_arb #(.NUM_INT(32), .WAIT_CYC(WC)) dut (
      .wic_clk             (clk),
      .pad_cpu_rst         (rst),
      .int_pending         (pend),
      .ctl_xx_awake_enable (msk),
      .cpu_arb_int_ack     (ack),
      .arb_int_vld         (vld),
      .arb_int_id          (id),
      .vec_int             (vec),
      .int_ack_vec         (ack_vec),
      .pending_clr         (clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // First set bit at or above the pointer, wrapping; -1 if none.
   function automatic int pick(input logic [31:0] m, input int unsigned p);
      for (int unsigned d = 0; d < 32; d++) begin
         int unsigned i;
         i = (p + d) % 32;
         if (m[i]) return int'(i);
      end
      return -1;
   endfunction

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_vld"}, 32'(vld), 32'd0);
      chk({tag, "_vec"}, 32'(vec), 32'd0);
      chk({tag, "_ackvec"}, 32'(ack_vec), 32'd0);
      chk({tag, "_clr"}, clr, 32'd0);
   endtask

   // mode 0: ack, 1: ack with same-cycle drop, 2: withdraw.
   // j: WAIT cycle in which the serviced bit drops (>= WC means never).
   task automatic run_txn(input logic [31:0] p, input logic [31:0] k,
                          input int unsigned hold, input int unsigned mode,
                          input int unsigned j);
      int          w;
      int          w2;
      int unsigned count;
      logic        exp_vld;
      pend = p;
      msk  = k;
      tick();
      w = pick(p & k, ptr_m);
      chk("vld_rise", 32'(vld), 32'd1);
      chk("id", 32'(id), 32'(w));
      for (int unsigned h = 0; h < hold; h++) begin
         msk = $urandom;
         tick();
         chk("hold_vld", 32'(vld), 32'd1);
         chk("hold_id", 32'(id), 32'(w));
         chk("hold_clr", clr, 32'd0);
      end
      if (mode == 2) begin
         pend[w] = 1'b0;
         tick();
         chk_idle_outs("withdraw");
         pend = '0;
         tick();
         return;
      end
      ack = 1'b1;
      if (mode == 1) pend[w] = 1'b0;
      tick();
      ack = 1'b0;
      chk("clr_vld", 32'(vld), 32'd0);
      chk("clr_vec", 32'(vec), 32'd1);
      chk("clr_ackvec", 32'(ack_vec), 32'(w));
      chk("clr_onehot", clr, 32'd1 << w);
      if (rr_en) ptr_m = (32'(w) + 1) % 32;
      tick();
      chk_idle_outs("wait0");
      if (mode == 1) count = 1;
      else if (j < WC) count = j + 1;
      else count = WC;
      for (int unsigned c = 0; c <= count; c++) begin
         if (mode != 1 && c == j && j < WC) pend[w] = 1'b0;
         ack = 1'($urandom % 2);
         tick();
         if (c < count) begin
            chk("waitq_vld", 32'(vld), 32'd0);
            chk("waitq_clr", clr, 32'd0);
         end else begin
            exp_vld = |(pend & msk);
            chk("repres_vld", 32'(vld), 32'(exp_vld));
            if (exp_vld) begin
               w2 = pick(pend & msk, ptr_m);
               chk("repres_id", 32'(id), 32'(w2));
            end
         end
      end
      ack  = 1'b0;
      pend = '0;
      tick();
      chk_idle_outs("cleanup");
      tick();
   endtask

   initial begin
`ifdef WIC_ARB_RR_EN
      rr_en = 1'b1;
`else
      rr_en = 1'b0;
`endif
      rst  = 1'b1;
      pend = '0;
      msk  = '0;
      ack  = 1'b0;
      tick();
      tick();
      chk_idle_outs("reset");
      rst = 1'b0;
      tick();
      chk_idle_outs("post_reset");

      run_txn(32'h0000_0001, 32'hFFFF_FFFF, 1, 0, 0);
      run_txn(32'h0008_0400, 32'h0008_0000, 2, 0, 1);
      run_txn(32'h0000_0004, 32'hFFFF_FFFF, 3, 2, 0);
      run_txn(32'h0000_0040, 32'hFFFF_FFFF, 0, 1, 0);

      // Stale pending bit 5 re-presented after WAIT times out.
      rst = 1'b1; tick(); rst = 1'b0; ptr_m = 0; tick();
      run_txn(32'h0000_0020, 32'hFFFF_FFFF, 0, 0, 99);
      rst = 1'b1; tick(); rst = 1'b0; ptr_m = 0; tick();
      run_txn(32'h0000_00A0, 32'hFFFF_FFFF, 0, 0, 99);

      // Reset while presenting.
      pend = 32'h0000_0008; msk = '1;
      tick();
      chk("rstreq_pre", 32'(vld), 32'd1);
      rst = 1'b1;
      tick();
      chk_idle_outs("rst_in_req");
      rst = 1'b0; pend = '0; ptr_m = 0;
      tick();

      // Reset during the clear pulse.
      pend = 32'h0000_0008;
      tick();
      ack = 1'b1;
      tick();
      ack = 1'b0;
      chk("rstclr_pre", 32'(vec), 32'd1);
      rst = 1'b1;
      tick();
      chk_idle_outs("rst_in_clr");
      rst = 1'b0; pend = '0; ptr_m = 0;
      tick();
      chk_idle_outs("rst_release");

      for (int n = 0; n < 60; n++) begin
         logic [31:0] p;
         logic [31:0] k;
         int unsigned b;
         p = $urandom;
         k = $urandom;
         b = $urandom_range(31, 0);
         p[b] = 1'b1;
         k[b] = 1'b1;
         run_txn(p, k, $urandom_range(3, 0), $urandom_range(2, 0), $urandom_range(6, 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
